de2_io_conditioner: RTL and testbench
=====================================

Name: de2_io_conditioner

Overview:
- Parametrised board-side I/O front end between DE2 pins and the processor's memory-mapped I/O buses (io_sw, io_push, io_hex*). Replaces pure wiring with real conditioning.
- Inputs:
  - two-flop synchronisation of switches and keys;
  - per-key debouncing;
  - press-event pulses.
- Outputs: registered 7-seg drive with a selectable raw/decode mode.
- Status: a sticky error flag for software writes to unused HEX bits.

Parameters:
NUM_SW, 17, number of slide switches forwarded (1..32)
NUM_KEY, 4, number of push buttons (1..16)
NUM_HEX, 8, number of 7-segment digits (1..8)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (>=1; 10 ms at 50 MHz)

Ports:
clk_i  input  1  system clock, single domain
rst_ni  input  1  asynchronous active-low reset
sw_pin_i  input  NUM_SW  raw switch pins, active-high
key_pin_i  input  NUM_KEY  raw key pins, active-low (pressed = 0)
io_sw_o  output  32  synchronised switches, zero-extended
io_push_o  output  32  [NUM_KEY-1:0] debounced pressed level; [16+NUM_KEY-1:16] one-cycle press pulses; all other bits 0
io_hex_i  input  32*NUM_HEX  processor HEX registers; digit k is at [32k+31:32k]
hex_mode_i  input  1  0 = raw segments, 1 = decode nibble
hex_pin_o  output  7*NUM_HEX  segment drive, active-low; digit k is at [7k+6:7k], bit order g..a = 6..0
err_clr_i  input  1  clear sticky error
err_o  output  1  sticky unused-bit error

Behaviour:
- Reset is asynchronous and active-low on rst_ni; one clock clk_i. Reset values:
  - all sync flops 0;
  - key synchroniser stages 1 (released);
  - debounced key state 0 (released);
  - debounce counters 0;
  - io_sw_o 0, io_push_o 0, err_o 0;
  - hex_pin_o all ones (blank).
- Switch path: two-flop synchroniser. io_sw_o is the second stage, zero-extended to 32 bits. A pin change appears on io_sw_o after exactly 2 rising edges.
- Key path, per key k:
  - two-flop synchroniser, then inverted to active-high `s_k`;
  - counter cnt_k of width clog2(DEBOUNCE_CYCLES+1).
- Debounce rule, each cycle:
  - if `s_k` equals the stable state: cnt_k <= 0;
  - else if cnt_k == DEBOUNCE_CYCLES-1: stable toggles and cnt_k <= 0;
  - else cnt_k increments.
  - Any single-cycle return to the stable value restarts the count (glitch rejection).
- Key latency: pin edge to io_push_o level change is 2 + DEBOUNCE_CYCLES edges.
- Press pulse: io_push_o[16+k] is 1 for exactly one cycle, the first cycle the stable state reads 1 (0->1 transition). There is no pulse on release. Keys are independent, so simultaneous presses give simultaneous pulses.
- HEX path: hex_pin_o is registered, with 1-cycle latency from io_hex_i / hex_mode_i.
  - Raw mode: digit k <= io_hex_i[32k+6:32k].
  - Decode mode: digit k <= active-low 7-seg pattern of io_hex_i[32k+3:32k], covering 0-9 and A-F. Examples: 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E.
  - A mode change takes effect on the next edge for all digits together.
- Error detection: used field is [6:0] in raw mode, [3:0] in decode mode.
  - err_o sets when any digit has a nonzero bit above its used field in the current mode.
  - err_o clears on err_clr_i.
  - Set wins over clear in the same cycle.
  - err_o is registered, with 1-cycle latency.
- Reset mid-debounce: counter discarded; key returns to released, with no pulse.

Optional Feature:
- Macro IO_SW_DEBOUNCE_EN.
- Defined: switches get the same debounce counter logic as keys (shared DEBOUNCE_CYCLES, no pulses, active-high). Switch latency becomes 2 + DEBOUNCE_CYCLES.
- Undefined: switches are synchronised only, with latency 2, and no switch counters are instantiated.

Test Plan:
- Use DEBOUNCE_CYCLES=4 throughout.
- Reset: assert rst_ni=0 asynchronously mid-cycle -> hex_pin_o=all ones, io_sw_o=0, io_push_o=0, err_o=0 immediately.
- Switch: sw_pin_i 0 -> 17'h1A5A5 -> io_sw_o=32'h0001A5A5 after exactly 2 edges (macro off) or 6 edges (macro on).
- Key press:
  - hold key_pin_i[2]=0 -> io_push_o[2]=1 after 6 edges; io_push_o[18] high for exactly 1 cycle; release -> io_push_o[2]=0 after 6 edges with no pulse.
  - glitch: key_pin_i[0] low for 3 cycles then high -> io_push_o stays 0.
- Decode: hex_mode_i=1, digit0=32'h8, digit7=32'hF -> hex_pin_o[6:0]=7'h00, hex_pin_o[55:49]=7'h0E one edge later; err_o=0.
- Error:
  - raw mode, digit3=32'h80 -> err_o=1 next edge;
  - hold err_clr_i with digit3 still 32'h80 -> err_o stays 1;
  - set digit3=0 and pulse err_clr_i -> err_o=0.
- Mode switch: digit0=32'h7F, toggle hex_mode_i 0->1 -> hex_pin_o[6:0] goes 7'h7F -> 7'h0E (decoded F); err_o=1 (bits [6:4] nonzero in decode mode).

Source files
------------

// File: rtl/de2_io_conditioner.sv
// DE2 board I/O front end: synchronised switches, debounced keys with press pulses,
// registered 7-segment drive (raw/decode) and a sticky unused-HEX-bit error flag.
// Define IO_SW_DEBOUNCE_EN to debounce the switches with the same counter rule as the keys.
module de2_io_conditioner #(
  parameter int NUM_SW          = 17,
  parameter int NUM_KEY         = 4,
  parameter int NUM_HEX         = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_SW-1:0]      sw_pin_i,
  input  logic [NUM_KEY-1:0]     key_pin_i,
  output logic [31:0]            io_sw_o,
  output logic [31:0]            io_push_o,
  input  logic [32*NUM_HEX-1:0]  io_hex_i,
  input  logic                   hex_mode_i,
  output logic [7*NUM_HEX-1:0]   hex_pin_o,
  input  logic                   err_clr_i,
  output logic                   err_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0]  sw_s1, sw_s2;
  logic [NUM_KEY-1:0] key_s1, key_s2;
  logic [NUM_KEY-1:0] key_stable, key_pulse;
  logic [CW-1:0]      key_cnt [NUM_KEY];
  logic [7*NUM_HEX-1:0] hex_next;
  logic               err_det;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_pin_i;
      sw_s2 <= sw_s1;
    end
  end

`ifdef IO_SW_DEBOUNCE_EN
  logic [NUM_SW-1:0] sw_stable;
  logic [CW-1:0]     sw_cnt [NUM_SW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_stable <= '0;
      for (int i = 0; i < NUM_SW; i++) sw_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (sw_s2[i] == sw_stable[i]) begin
          sw_cnt[i] <= '0;
        end else if (sw_cnt[i] == CNT_LAST) begin
          sw_stable[i] <= ~sw_stable[i];
          sw_cnt[i]    <= '0;
        end else begin
          sw_cnt[i] <= sw_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign io_sw_o = 32'(sw_stable);
`else
  assign io_sw_o = 32'(sw_s2);
`endif

  // Keys are active-low at the pin; the counter compares the inverted (pressed = 1) value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_s1     <= '1;
      key_s2     <= '1;
      key_stable <= '0;
      key_pulse  <= '0;
      for (int i = 0; i < NUM_KEY; i++) key_cnt[i] <= '0;
    end else begin
      key_s1 <= key_pin_i;
      key_s2 <= key_s1;
      for (int i = 0; i < NUM_KEY; i++) begin
        key_pulse[i] <= 1'b0;
        if (~key_s2[i] == key_stable[i]) begin
          key_cnt[i] <= '0;
        end else if (key_cnt[i] == CNT_LAST) begin
          key_stable[i] <= ~key_stable[i];
          key_pulse[i]  <= ~key_stable[i];
          key_cnt[i]    <= '0;
        end else begin
          key_cnt[i] <= key_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    io_push_o = '0;
    io_push_o[NUM_KEY-1:0]  = key_stable;
    io_push_o[16 +: NUM_KEY] = key_pulse;
  end

  // Error detection looks only at bits above the field the current mode consumes.
  always_comb begin
    hex_next = '1;
    err_det  = 1'b0;
    for (int k = 0; k < NUM_HEX; k++) begin
      if (hex_mode_i) begin
        hex_next[7*k +: 7] = seg_decode(io_hex_i[32*k +: 4]);
        err_det = err_det | (|io_hex_i[32*k+4 +: 28]);
      end else begin
        hex_next[7*k +: 7] = io_hex_i[32*k +: 7];
        err_det = err_det | (|io_hex_i[32*k+7 +: 25]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hex_pin_o <= '1;
      err_o     <= 1'b0;
    end else begin
      hex_pin_o <= hex_next;
      if (err_det) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_de2_io_conditioner.sv
// Self-checking bench for de2_io_conditioner (DEBOUNCE_CYCLES = 4): directed sequences,
// a decode/error vector table and randomized stimulus against a history-window model.
module tb_de2_io_conditioner;

  localparam int NUM_SW  = 17;
  localparam int NUM_KEY = 4;
  localparam int NUM_HEX = 8;
  localparam int DB      = 4;
`ifdef IO_SW_DEBOUNCE_EN
  localparam int SW_LAT = 2 + DB;
`else
  localparam int SW_LAT = 2;
`endif

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_SW-1:0]     sw_pin;
  logic [NUM_KEY-1:0]    key_pin;
  logic [31:0]           io_sw;
  logic [31:0]           io_push;
  logic [32*NUM_HEX-1:0] io_hex;
  logic                  hex_mode;
  logic [7*NUM_HEX-1:0]  hex_pin;
  logic                  err_clr;
  logic                  err;

  int checks   = 0;
  int failures = 0;

  logic [NUM_KEY-1:0]   key_samp [$];
  logic [NUM_SW-1:0]    sw_samp  [$];
  logic [NUM_KEY-1:0]   m_key, m_pulse;
  logic [NUM_SW-1:0]    m_sw;
  logic [7*NUM_HEX-1:0] m_hex;
  logic                 m_err;

  typedef struct {
    logic        mode;
    logic [31:0] word0;
    logic [6:0]  seg0;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  de2_io_conditioner #(
    .NUM_SW(NUM_SW), .NUM_KEY(NUM_KEY), .NUM_HEX(NUM_HEX), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_pin_i(sw_pin), .key_pin_i(key_pin),
    .io_sw_o(io_sw), .io_push_o(io_push), .io_hex_i(io_hex), .hex_mode_i(hex_mode),
    .hex_pin_o(hex_pin), .err_clr_i(err_clr), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void hexModel(input logic mode, input logic [32*NUM_HEX-1:0] hx,
                                   output logic [7*NUM_HEX-1:0] h, output logic e);
    logic [31:0] w;
    e = 1'b0;
    h = '1;
    for (int d = 0; d < NUM_HEX; d++) begin
      w = hx[32*d +: 32];
      if (mode) begin
        h[7*d +: 7] = SEG[w[3:0]];
        if (w > 32'd15) e = 1'b1;
      end else begin
        h[7*d +: 7] = w[6:0];
        if (w > 32'd127) e = 1'b1;
      end
    end
  endfunction

  // A debounced level flips once the last DB synchronised samples all disagree with it.
  task automatic modelReset();
    key_samp.delete();
    sw_samp.delete();
    for (int i = 0; i < DB + 2; i++) begin
      key_samp.push_back('1);
      sw_samp.push_back('0);
    end
    m_key   = '0;
    m_pulse = '0;
    m_sw    = '0;
    m_hex   = '1;
    m_err   = 1'b0;
  endtask

  task automatic applyStimulus();
    logic [7*NUM_HEX-1:0] nh;
    logic nd;
    logic clr;
    logic flip;
    int n;
    hexModel(hex_mode, io_hex, nh, nd);
    clr = err_clr;
    key_samp.push_back(key_pin);
    sw_samp.push_back(sw_pin);
    @(posedge clk);
    #1;
    m_hex = nh;
    if (nd) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    n = key_samp.size();
    m_pulse = '0;
    for (int k = 0; k < NUM_KEY; k++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++)
        if (!key_samp[n-3-j][k] == m_key[k]) flip = 1'b0;
      if (flip) begin
        m_key[k] = ~m_key[k];
        if (m_key[k]) m_pulse[k] = 1'b1;
      end
    end
`ifdef IO_SW_DEBOUNCE_EN
    for (int b = 0; b < NUM_SW; b++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++)
        if (sw_samp[n-3-j][b] == m_sw[b]) flip = 1'b0;
      if (flip) m_sw[b] = ~m_sw[b];
    end
`else
    m_sw = sw_samp[n-2];
`endif
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] push_exp;
    push_exp = '0;
    push_exp[NUM_KEY-1:0]   = m_key;
    push_exp[16 +: NUM_KEY] = m_pulse;
    checkOutput({tag, ".io_sw"}, 64'(io_sw), 64'(32'(m_sw)));
    checkOutput({tag, ".io_push"}, 64'(io_push), 64'(push_exp));
    checkOutput({tag, ".hex"}, 64'(hex_pin), 64'(m_hex));
    checkOutput({tag, ".err"}, 64'(err), 64'(m_err));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0,   7'h40, 1'b0};
    vecs[1]  = '{1'b1, 32'h8,   7'h00, 1'b0};
    vecs[2]  = '{1'b1, 32'hF,   7'h0E, 1'b0};
    vecs[3]  = '{1'b1, 32'hA,   7'h08, 1'b0};
    vecs[4]  = '{1'b1, 32'h3,   7'h30, 1'b0};
    vecs[5]  = '{1'b0, 32'h7F,  7'h7F, 1'b0};
    vecs[6]  = '{1'b0, 32'h55,  7'h55, 1'b0};
    vecs[7]  = '{1'b1, 32'h10,  7'h40, 1'b1};
    vecs[8]  = '{1'b0, 32'h80,  7'h00, 1'b1};
    vecs[9]  = '{1'b1, 32'h2B,  7'h03, 1'b1};
    vecs[10] = '{1'b0, 32'h0,   7'h00, 1'b0};
    vecs[11] = '{1'b1, 32'h7,   7'h78, 1'b0};

    rst_n    = 1'b0;
    sw_pin   = '0;
    key_pin  = '1;
    io_hex   = '0;
    hex_mode = 1'b0;
    err_clr  = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Build up non-reset state, then drop reset between edges.
    sw_pin  = 17'h1FFFF;
    key_pin = '0;
    io_hex[31:0] = 32'h155;
    repeat (3) applyStimulus();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.hex", 64'(hex_pin), 64'({(7*NUM_HEX){1'b1}}));
    checkOutput("rst.io_sw", 64'(io_sw), 64'h0);
    checkOutput("rst.io_push", 64'(io_push), 64'h0);
    checkOutput("rst.err", 64'(err), 64'h0);
    modelReset();
    sw_pin  = '0;
    key_pin = '1;
    io_hex  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkAll("post_rst");

    sw_pin = 17'h1A5A5;
    for (int i = 1; i <= SW_LAT; i++) begin
      applyStimulus();
      checkOutput("sw_latency", 64'(io_sw), (i == SW_LAT) ? 64'h1A5A5 : 64'h0);
    end

    key_pin = 4'b1011;
    for (int i = 1; i <= 2 + DB; i++) begin
      applyStimulus();
      checkOutput("key_press", 64'(io_push), (i == 2 + DB) ? 64'h0004_0004 : 64'h0);
    end
    applyStimulus();
    checkOutput("key_pulse_end", 64'(io_push), 64'h4);
    applyStimulus();
    key_pin = 4'b1111;
    for (int i = 1; i <= 2 + DB; i++) begin
      applyStimulus();
      checkOutput("key_release", 64'(io_push), (i == 2 + DB) ? 64'h0 : 64'h4);
    end
    applyStimulus();
    checkOutput("key_no_rel_pulse", 64'(io_push), 64'h0);

    key_pin = 4'b1110;
    repeat (3) applyStimulus();
    key_pin = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput("key_glitch", 64'(io_push), 64'h0);
    end

    hex_mode = 1'b1;
    io_hex[31:0]    = 32'h8;
    io_hex[255:224] = 32'hF;
    applyStimulus();
    checkOutput("dec.digit0", 64'(hex_pin[6:0]), 64'h00);
    checkOutput("dec.digit7", 64'(hex_pin[55:49]), 64'h0E);
    checkOutput("dec.err", 64'(err), 64'h0);
    checkAll("dec");

    hex_mode = 1'b0;
    io_hex   = '0;
    io_hex[127:96] = 32'h80;
    applyStimulus();
    checkOutput("err.set", 64'(err), 64'h1);
    err_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("err.set_wins", 64'(err), 64'h1);
    end
    io_hex[127:96] = 32'h0;
    applyStimulus();
    checkOutput("err.clear", 64'(err), 64'h0);
    err_clr = 1'b0;
    applyStimulus();
    checkOutput("err.stays_clear", 64'(err), 64'h0);

    io_hex[31:0] = 32'h7F;
    applyStimulus();
    checkOutput("mode.raw", 64'(hex_pin[6:0]), 64'h7F);
    checkOutput("mode.raw_err", 64'(err), 64'h0);
    hex_mode = 1'b1;
    applyStimulus();
    checkOutput("mode.dec", 64'(hex_pin[6:0]), 64'h0E);
    checkOutput("mode.dec_err", 64'(err), 64'h1);

    err_clr = 1'b1;
    for (int v = 0; v < 12; v++) begin
      io_hex = '0;
      io_hex[31:0] = vecs[v].word0;
      hex_mode = vecs[v].mode;
      applyStimulus();
      checkOutput($sformatf("vec%0d.seg", v), 64'(hex_pin[6:0]), 64'(vecs[v].seg0));
      checkOutput($sformatf("vec%0d.err", v), 64'(err), 64'(vecs[v].err));
    end
    err_clr = 1'b0;

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) sw_pin[$urandom_range(0, NUM_SW - 1)] ^= 1'b1;
      for (int k = 0; k < NUM_KEY; k++)
        if ($urandom_range(0, 5) == 0) key_pin[k] = ~key_pin[k];
      hex_mode = 1'($urandom_range(0, 1));
      err_clr  = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < NUM_HEX; d++) begin
        case ($urandom_range(0, 9))
          0:       io_hex[32*d +: 32] = $urandom;
          1, 2:    io_hex[32*d +: 32] = 32'($urandom_range(0, 127));
          default: io_hex[32*d +: 32] = 32'($urandom_range(0, 15));
        endcase
      end
      applyStimulus();
      checkAll("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
